// File: rtl/mac_acc_stage.sv
`default_nettype none
// ============================================================================
// Module  : mac_acc_stage
// Brief   : Accumulates 16-lane MAC partial sums into neuron values, shifts
//           them, and streams results through a 2-entry output FIFO.
//           Optional macro ACC_SAT_EN saturates instead of truncating.
// Revision: 1.0 - initial release
// ============================================================================
module mac_acc_stage #(
    parameter int TILE_W = 4,
    parameter int OUT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [TILE_W-1:0] cfg_tiles,
    input  logic [7:0]        cfg_outs,
    input  logic [3:0]        cfg_shift,
    input  logic              in_valid,
    input  logic [11:0]       in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [OUT_W-1:0]  out_data,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    localparam int SUM_W = 12 + TILE_W;
    localparam int EXT_W = (SUM_W > OUT_W) ? SUM_W : OUT_W;
    localparam logic [OUT_W-1:0] c_OUT_MAX = '1;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_ACC  = 1'b1
    } state_t;

    state_t              r_state;
    logic [TILE_W-1:0]   r_tiles;
    logic [7:0]          r_outs;
    logic [3:0]          r_shift;
    logic [SUM_W-1:0]    r_acc;
    logic [TILE_W-1:0]   r_tile_cnt;
    logic [7:0]          r_neuron_cnt;
    logic                r_done;

    // Two-entry FIFO held as head/tail registers; head always drives out_data.
    logic [1:0]          r_count;
    logic [OUT_W-1:0]    r_head;
    logic [OUT_W-1:0]    r_tail;

    logic                w_in_ready;
    logic                w_accept;
    logic                w_pop;
    logic                w_last_beat;
    logic                w_last_neuron;
    logic [SUM_W-1:0]    w_sum;
    logic [SUM_W-1:0]    w_shifted;
    logic [EXT_W-1:0]    w_ext;
    logic [OUT_W-1:0]    w_result;

    assign w_in_ready    = (r_state == S_ACC) && (r_count < 2'd2);
    assign w_accept      = in_valid && w_in_ready;
    assign w_pop         = (r_count != 2'd0) && out_ready;
    assign w_last_beat   = w_accept && (r_tile_cnt == r_tiles);
    assign w_last_neuron = w_last_beat && (r_neuron_cnt == r_outs);

    assign w_sum     = r_acc + SUM_W'(in_data);
    assign w_shifted = w_sum >> r_shift;
    assign w_ext     = EXT_W'(w_shifted);

`ifdef ACC_SAT_EN
    assign w_result = (w_ext > EXT_W'(c_OUT_MAX)) ? c_OUT_MAX : w_ext[OUT_W-1:0];
`else
    assign w_result = w_ext[OUT_W-1:0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_tiles      <= '0;
            r_outs       <= '0;
            r_shift      <= '0;
            r_acc        <= '0;
            r_tile_cnt   <= '0;
            r_neuron_cnt <= '0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_tiles      <= cfg_tiles;
                        r_outs       <= cfg_outs;
                        r_shift      <= cfg_shift;
                        r_acc        <= '0;
                        r_tile_cnt   <= '0;
                        r_neuron_cnt <= '0;
                        r_state      <= S_ACC;
                    end
                end
                S_ACC: begin
                    if (w_accept) begin
                        if (w_last_beat) begin
                            r_acc      <= '0;
                            r_tile_cnt <= '0;
                            if (w_last_neuron) begin
                                r_neuron_cnt <= '0;
                                r_state      <= S_IDLE;
                                r_done       <= 1'b1;
                            end else begin
                                r_neuron_cnt <= r_neuron_cnt + 8'd1;
                            end
                        end else begin
                            r_acc      <= w_sum;
                            r_tile_cnt <= r_tile_cnt + TILE_W'(1);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // A push only happens with count < 2, so push+pop always finds one entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= 2'd0;
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            case ({w_last_beat, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_head <= w_result;
                    end else begin
                        r_tail <= w_result;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_head  <= r_tail;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    r_head <= w_result;
                end
                default: begin
                    r_count <= r_count;
                end
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = (r_count != 2'd0);
    assign out_data  = r_head;
    assign busy      = (r_state == S_ACC) || (r_count != 2'd0);
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_mac_acc_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_mac_acc_stage
// Brief   : Self-checking bench for mac_acc_stage: directed scenarios plus
//           randomized traffic against a queue-based reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mac_acc_stage;

    localparam int TILE_W = 4;
    localparam int OUT_W  = 8;
    localparam int c_MAX  = (1 << OUT_W) - 1;
`ifdef ACC_SAT_EN
    localparam int c_SAT_EXP = 255;
`else
    localparam int c_SAT_EXP = 252;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [TILE_W-1:0] cfg_tiles = '0;
    logic [7:0]        cfg_outs = '0;
    logic [3:0]        cfg_shift = '0;
    logic              in_valid = 1'b0;
    logic [11:0]       in_data = '0;
    logic              in_ready;
    logic              out_valid;
    logic [OUT_W-1:0]  out_data;
    logic              out_ready = 1'b0;
    logic              busy;
    logic              done;

    mac_acc_stage #(.TILE_W(TILE_W), .OUT_W(OUT_W)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cfg_tiles (cfg_tiles),
        .cfg_outs  (cfg_outs),
        .cfg_shift (cfg_shift),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;
    bit chk_en   = 1'b0;
    int got[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int fmt(input int v);
`ifdef ACC_SAT_EN
        return (v > c_MAX) ? c_MAX : v;
`else
        return v & c_MAX;
`endif
    endfunction

    // Reference model: job flag, running sum, beat/neuron counts, result queue.
    bit m_active = 1'b0;
    int m_tiles, m_outs, m_shift;
    int m_acc = 0, m_beats = 0, m_neur = 0;
    int m_q[$];
    bit m_done = 1'b0;
    bit m_take, m_give;

    always @(posedge clk) begin
        if (rst) begin
            m_active = 1'b0;
            m_acc    = 0;
            m_beats  = 0;
            m_neur   = 0;
            m_q.delete();
            m_done   = 1'b0;
        end else begin
            m_take = m_active && (m_q.size() < 2) && in_valid;
            m_give = (m_q.size() > 0) && out_ready;
            m_done = 1'b0;
            if (m_give) void'(m_q.pop_front());
            if (!m_active) begin
                if (start) begin
                    m_tiles  = int'(cfg_tiles);
                    m_outs   = int'(cfg_outs);
                    m_shift  = int'(cfg_shift);
                    m_acc    = 0;
                    m_beats  = 0;
                    m_neur   = 0;
                    m_active = 1'b1;
                end
            end else if (m_take) begin
                m_acc += int'(in_data);
                if (m_beats == m_tiles) begin
                    m_q.push_back(fmt(m_acc >> m_shift));
                    m_acc   = 0;
                    m_beats = 0;
                    if (m_neur == m_outs) begin
                        m_neur   = 0;
                        m_active = 1'b0;
                        m_done   = 1'b1;
                    end else begin
                        m_neur++;
                    end
                end else begin
                    m_beats++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", in_ready, m_active && (m_q.size() < 2));
            chk("out_valid", out_valid, m_q.size() > 0);
            if (m_q.size() > 0) chk("out_data", out_data, m_q[0]);
            chk("busy", busy, m_active || (m_q.size() > 0));
            chk("done", done, m_done);
            if (out_valid && out_ready) got.push_back(int'(out_data));
            if (done) n_done++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input int t, input int o, input int s);
        cfg_tiles = TILE_W'(t);
        cfg_outs  = 8'(o);
        cfg_shift = 4'(s);
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic send_beat(input int d);
        int k;
        k = 0;
        in_valid = 1'b1;
        in_data  = 12'(d);
        while (!in_ready && k < 60) begin
            tick();
            k++;
        end
        if (k == 60) chk("beat_timeout", in_ready, 1);
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1);
    end

    initial begin
        tick();
        chk_en = 1'b1;
        tick();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;

        // Beats offered while idle must be refused.
        in_valid = 1'b1;
        in_data  = 12'd55;
        tick();
        chk("idle_in_ready", in_ready, 0);
        in_valid = 1'b0;

        // Basic job
        out_ready = 1'b1;
        start_job(3, 0, 2);
        send_beat(100); send_beat(200); send_beat(300); send_beat(400);
        chk("basic_valid", out_valid, 1);
        chk("basic_data", out_data, 250);
        chk("basic_model", m_q.size() > 0 ? m_q[0] : -1, 250);
        chk("basic_done", done, 1);
        tick();
        chk("basic_busy_after", busy, 0);
        chk("basic_done_after", done, 0);

        // Saturation / truncation
        start_job(3, 0, 0);
        send_beat(4095); send_beat(4095); send_beat(4095); send_beat(4095);
        chk("sat_data", out_data, c_SAT_EXP);
        tick();

        // Backpressure
        got.delete();
        n_done    = 0;
        out_ready = 1'b0;
        start_job(0, 3, 0);
        send_beat(1); send_beat(2);
        chk("bp_full_ready", in_ready, 0);
        tick();
        chk("bp_full_ready2", in_ready, 0);
        out_ready = 1'b1;
        send_beat(3); send_beat(4);
        repeat (4) tick();
        chk("bp_count", got.size(), 4);
        if (got.size() == 4) begin
            for (int i = 0; i < 4; i++) chk($sformatf("bp_order%0d", i), got[i], i + 1);
        end
        chk("bp_done", n_done, 1);

        // Simultaneous push and pop
        got.delete();
        out_ready = 1'b0;
        start_job(0, 1, 0);
        send_beat(5);
        chk("pp_head", out_data, 5);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 12'd6;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("pp_valid", out_valid, 1);
        chk("pp_data", out_data, 6);
        out_ready = 1'b1;
        repeat (2) tick();
        chk("pp_count", got.size(), 2);
        if (got.size() == 2) begin
            chk("pp_first", got[0], 5);
            chk("pp_second", got[1], 6);
        end

        // Reset mid-job
        n_done = 0;
        start_job(3, 0, 0);
        send_beat(10); send_beat(20);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_in_ready", in_ready, 0);
        chk("mid_out_valid", out_valid, 0);
        chk("mid_out_data", out_data, 0);
        chk("mid_busy", busy, 0);
        chk("mid_done", done, 0);
        start_job(3, 0, 0);
        send_beat(10); send_beat(10); send_beat(10); send_beat(10);
        chk("mid_result", out_data, 40);
        tick();
        chk("mid_done_cnt", n_done, 1);

        // Start ignored while accumulating
        start_job(1, 0, 0);
        send_beat(7);
        cfg_tiles = '0;
        cfg_outs  = 8'd5;
        cfg_shift = 4'd3;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        send_beat(9);
        chk("ign_valid", out_valid, 1);
        chk("ign_data", out_data, 16);
        tick();

        // Randomized traffic, checked every cycle by the model.
        for (int c = 0; c < 5000; c++) begin
            in_valid  = ($urandom % 3) != 0;
            in_data   = ($urandom % 4 == 0) ? 12'(4095 - $urandom_range(0, 15)) : 12'($urandom_range(0, 4095));
            out_ready = ($urandom % 4) != 0;
            start     = ($urandom % 6) == 0;
            cfg_tiles = TILE_W'($urandom_range(0, 15));
            cfg_outs  = 8'($urandom_range(0, 6));
            cfg_shift = 4'($urandom_range(0, 15));
            rst       = ($urandom % 800) == 0;
            tick();
        end
        rst       = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (5) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
